// File: rtl/pe_array_dbuf_if.sv
// pe_array_dbuf_if: handshake/bus bundle for the double-buffered systolic array.
//   Weight path : wt_we, wt_col, wt_in -> shadow bank; wt_ready back.
//   Swap control: wt_swap_req in; wt_swap_done / wt_swap_err pulses back.
//   Activations : data_in, data_valid in; data_ready back.
//   Results     : psum_out, psum_out_valid from the array.
//   Optional    : bias_we, bias_in when PE_ARRAY_BIAS_EN is defined.
// master = fetch/control side driving the array, slave = the array itself.
interface pe_array_dbuf_if #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                         wt_we;
  logic [CW-1:0]                wt_col;
  logic [ROWS*DATA_WIDTH-1:0]   wt_in;
  logic                         wt_ready;
  logic                         wt_swap_req;
  logic                         wt_swap_done;
  logic                         wt_swap_err;
  logic [ROWS*DATA_WIDTH-1:0]   data_in;
  logic                         data_valid;
  logic                         data_ready;
  logic [COLS*ACC_WIDTH-1:0]    psum_out;
  logic                         psum_out_valid;

`ifdef PE_ARRAY_BIAS_EN
  logic                         bias_we;
  logic [COLS*ACC_WIDTH-1:0]    bias_in;

  modport master (
    output wt_we, wt_col, wt_in, wt_swap_req, data_in, data_valid, bias_we, bias_in,
    input  wt_ready, wt_swap_done, wt_swap_err, data_ready, psum_out, psum_out_valid
  );
  modport slave (
    input  wt_we, wt_col, wt_in, wt_swap_req, data_in, data_valid, bias_we, bias_in,
    output wt_ready, wt_swap_done, wt_swap_err, data_ready, psum_out, psum_out_valid
  );
`else
  modport master (
    output wt_we, wt_col, wt_in, wt_swap_req, data_in, data_valid,
    input  wt_ready, wt_swap_done, wt_swap_err, data_ready, psum_out, psum_out_valid
  );
  modport slave (
    input  wt_we, wt_col, wt_in, wt_swap_req, data_in, data_valid,
    output wt_ready, wt_swap_done, wt_swap_err, data_ready, psum_out, psum_out_valid
  );
`endif
endinterface

// File: rtl/pe_array_dbuf.sv
// pe_array_dbuf: weight-stationary ROWS x COLS signed MAC array with a
// double-buffered weight bank. New weights are written into a shadow bank
// while the active bank computes; a swap request drains all in-flight beats
// and then commits shadow -> active in a single cycle.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears banks, pipes, FSM)
//   bus   : pe_array_dbuf_if.slave
//           wt_we/wt_col/wt_in  write one shadow column (row r = slice r)
//           wt_ready            shadow writes accepted (IDLE only)
//           wt_swap_req         commit request; wt_swap_done / wt_swap_err pulses
//           data_in/data_valid  activation beat; data_ready accepts (IDLE only)
//           psum_out/_valid     bottom-row partial sums, column c = slice c
//
// Optional feature macro: PE_ARRAY_BIAS_EN adds a double-buffered per-column
// bias (bias_we/bias_in) that feeds the top-row psum input after commit.
module pe_array_dbuf #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  pe_array_dbuf_if.slave bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW = $clog2(ROWS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Product is full 2*DATA_WIDTH precision, sign-extended, and the sum wraps.
  function automatic logic signed [ACC_WIDTH-1:0] mac(
    input logic signed [ACC_WIDTH-1:0]  psum_in,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] w
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = a * w;
    return psum_in + ACC_WIDTH'(prod);
  endfunction

  logic [1:0]      state;
  logic [NW-1:0]   inflight;
  logic [COLS-1:0] loaded_mask;
  logic            swap_err;
  logic            accept;
  logic            wr_en;
  logic            drained;
  logic            out_vld;
  logic            commit;

  logic signed [DATA_WIDTH-1:0] w_shadow [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] w_active [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] row_data [ROWS];
  logic signed [ACC_WIDTH-1:0]  top_psum [COLS];
  logic signed [ACC_WIDTH-1:0]  psum_p   [ROWS][COLS];
  logic [ROWS-1:0]              vld_p;

  assign bus.data_ready   = rst_n && (state == S_IDLE);
  assign bus.wt_ready     = rst_n && (state == S_IDLE);
  assign bus.wt_swap_done = (state == S_COMMIT);
  assign bus.wt_swap_err  = swap_err;

  assign commit  = (state == S_COMMIT);
  assign accept  = bus.data_valid && bus.data_ready;
  assign wr_en   = bus.wt_we && bus.wt_ready && (int'(bus.wt_col) < COLS);
  // No beats are accepted outside IDLE, so the count reaches zero as soon as
  // the last in-flight result leaves; committing on that edge saves a cycle.
  assign drained = (inflight == '0) || ((inflight == NW'(1)) && out_vld);

  // Swap controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      swap_err <= 1'b0;
    end else begin
      swap_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.wt_swap_req) begin
            if (&loaded_mask) state    <= S_DRAIN;
            else              swap_err <= 1'b1;
          end
        end
        S_DRAIN:  if (drained) state <= S_COMMIT;
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, out_vld})
        2'b10:   inflight <= inflight + NW'(1);
        2'b01:   inflight <= inflight - NW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_mask <= '0;
    end else if (commit) begin
      loaded_mask <= '0;
    end else if (wr_en) begin
      loaded_mask[bus.wt_col] <= 1'b1;
    end
  end

  // Weight banks: shadow written per column, active replaced wholesale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          w_shadow[r][c] <= '0;
          w_active[r][c] <= '0;
        end
    end else begin
      if (wr_en)
        for (int r = 0; r < ROWS; r++)
          w_shadow[r][bus.wt_col] <= bus.wt_in[r*DATA_WIDTH +: DATA_WIDTH];
      if (commit)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            w_active[r][c] <= w_shadow[r][c];
    end
  end

`ifdef PE_ARRAY_BIAS_EN
  logic signed [ACC_WIDTH-1:0] bias_shadow [COLS];
  logic signed [ACC_WIDTH-1:0] bias_active [COLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        bias_shadow[c] <= '0;
        bias_active[c] <= '0;
      end
    end else begin
      if (bus.bias_we && bus.wt_ready)
        for (int c = 0; c < COLS; c++)
          bias_shadow[c] <= bus.bias_in[c*ACC_WIDTH +: ACC_WIDTH];
      if (commit)
        for (int c = 0; c < COLS; c++)
          bias_active[c] <= bias_shadow[c];
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) top_psum[c] = bias_active[c];
  end
`else
  always_comb begin
    for (int c = 0; c < COLS; c++) top_psum[c] = '0;
  end
`endif

  // Stage p0..p(r-1): input skew, row r sees its slice r cycles late
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_row0
      assign row_data[0] = bus.data_in[0 +: DATA_WIDTH];
    end else begin : g_rowr
      logic signed [DATA_WIDTH-1:0] data_p [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) data_p[i] <= '0;
        end else begin
          data_p[0] <= bus.data_in[r*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < r; i++) data_p[i] <= data_p[i-1];
        end
      end
      assign row_data[r] = data_p[r-1];
    end
  end

  // Valid line: ROWS-1 skew stages plus the MAC stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < ROWS; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // MAC stage: psum flows down each column, weights stay put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          psum_p[r][c] <= '0;
    end else begin
      for (int c = 0; c < COLS; c++)
        psum_p[0][c] <= mac(top_psum[c], row_data[0], w_active[0][c]);
      for (int r = 1; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          psum_p[r][c] <= mac(psum_p[r-1][c], row_data[r], w_active[r][c]);
    end
  end

  assign out_vld            = vld_p[ROWS-1];
  assign bus.psum_out_valid = out_vld;
  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign bus.psum_out[c*ACC_WIDTH +: ACC_WIDTH] = psum_p[ROWS-1][c];
  end

endmodule

// File: doc/pe_array_dbuf.md
# pe_array_dbuf

Parametrised weight-stationary systolic array (ROWS x COLS signed MACs). It adds a double-buffered weight bank and a swap controller that drains in-flight data before committing new weights, so the next tile's weights load while the current tile computes. It sits between the activation/weight fetch logic and the output accumulator/requantiser in the conv datapath.

## Interface
- ROWS, 16, input channels (array height, skew depth)
- COLS, 16, output channels (array width)
- DATA_WIDTH, 8, signed activation/weight width
- ACC_WIDTH, 32, signed partial-sum width
- CW, $clog2(COLS), weight column index width (derived localparam)

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- wt_we  in  1  write one shadow-bank column
- wt_col  in  CW  column index for wt_we
- wt_in  in  ROWS*DATA_WIDTH  column weights, slice r -> row r
- wt_ready  out  1  shadow writes accepted
- wt_swap_req  in  1  request shadow->active commit (pulse)
- wt_swap_done  out  1  one-cycle pulse when commit occurs
- wt_swap_err  out  1  one-cycle pulse, request rejected
- data_in  in  ROWS*DATA_WIDTH  activation vector, slice r -> row r
- data_valid  in  1  activation beat valid
- data_ready  out  1  array accepts beats
- psum_out  out  COLS*ACC_WIDTH  bottom-row sums, slice c -> column c
- psum_out_valid  out  1  psum_out holds a result

## Operation
- Per PE: psum_reg <= psum_in + sext(data*w_active); product signed 2*DATA_WIDTH, sign-extended; sum wraps mod 2^ACC_WIDTH. PEs compute every cycle; validity is tracked separately.
- Input skew: row r sees data slice r delayed r cycles. The accepted-beat valid (data_valid & data_ready) travels through an identical delay line, plus 1 stage for the MAC.
- Top-row psum_in = 0 (see Configuration).
- Shadow bank: wt_we & wt_ready & wt_col<COLS writes wt_in into shadow column wt_col and sets loaded_mask[wt_col]. wt_col>=COLS is ignored. Rewriting a column overwrites it.
- In-flight counter: +1 on each accepted beat, -1 on psum_out_valid, net 0 when both occur. Range 0..ROWS.
- FSM:
  - IDLE: data_ready=1, wt_ready=1. On wt_swap_req with loaded_mask all ones -> DRAIN. With a partial mask -> pulse wt_swap_err and stay in IDLE.
  - DRAIN: data_ready=0, wt_ready=0. Wait for in-flight==0 -> COMMIT.
  - COMMIT: active <= shadow (all PEs in one cycle), loaded_mask cleared, wt_swap_done=1 -> IDLE.
- wt_swap_req outside IDLE is ignored, with no error.
- The shadow bank is not cleared by a commit; its contents are retained but the mask is cleared, so a full reload is required.
- data_valid while data_ready=0: the beat is not accepted and produces no valid output.

## Timing
- Latency: beat accepted at cycle T -> psum_out_valid at T+ROWS, with psum_out = sum_r data[r]*w[r][c].
- Throughput: 1 beat/cycle in IDLE.
- Swap: request at T with in-flight=0 -> DRAIN at T+1, COMMIT at T+2 (done pulse), IDLE at T+3. With k beats in flight, DRAIN persists until the last of them is output.
- Reset values: psum_out=0, psum_out_valid=0, data_ready=1 after reset release (0 during reset), wt_ready likewise, wt_swap_done=0, wt_swap_err=0. Both banks, mask, counter, skew and valid lines = 0, FSM=IDLE.
- Reset mid-operation: all in-flight results are discarded, with no valid output afterwards.

## Configuration
- PE_ARRAY_BIAS_EN defined: adds ports bias_we (in, 1) and bias_in (in, COLS*ACC_WIDTH).
  - bias_we & wt_ready writes the shadow bias register.
  - COMMIT copies shadow bias to active bias, and the top-row psum_in[c] = active bias[c].
  - Bias load does not affect loaded_mask.
  - Reset clears both bias registers.
- Undefined: no bias ports, and the top-row psum_in is constant 0.

## Test plan
- ROWS=COLS=4, active weights w[r][c]=r+1, single beat data=(1,2,3,4) at T -> psum_out_valid at T+4, every column = 30, valid for exactly 1 cycle.
- Back-to-back beats (1,1,1,1),(-1,-1,-1,-1) with weights all 127 -> consecutive outputs 508 then -508 on every column.
- Swap with only 3 of 4 columns loaded -> wt_swap_err pulse, FSM stays IDLE, data_ready stays 1. Load 4th column, request again -> wt_swap_done after DRAIN+COMMIT.
- Swap requested 1 cycle after a beat -> data_ready low until that beat's psum_out_valid, done the following cycle. The beat's result uses the old weights and the next beat uses the new ones.
- Overflow: ACC_WIDTH=16, weights all -128, data all -128, ROWS=4 -> 4*16384=65536 wraps to 0.
- rst_n asserted with 2 beats in flight -> no psum_out_valid afterwards, psum_out=0, and weights read 0 (a beat yields 0). With PE_ARRAY_BIAS_EN, bias 5 committed -> a zero-data beat outputs 5.
